// File: rtl/reg_context_dma_if.sv
// Bus bundle between the context DMA engine, the register file and data memory.
interface reg_context_dma_if;
    logic          save_req;
    logic          restore_req;
    logic [31:0]   base_addr;
    logic          busy;
    logic          done;
    logic          rf_read_mem;
    logic          rf_write_mem;
    logic          rf_busywait;
    logic [1023:0] rf_out_data;
    logic [1023:0] rf_in_data;
    logic [31:0]   mem_address;
    logic [31:0]   mem_writedata;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_readdata;
    logic          mem_busywait;

    modport slave (
        input  save_req, restore_req, base_addr, rf_busywait, rf_out_data,
               mem_readdata, mem_busywait,
        output busy, done, rf_read_mem, rf_write_mem, rf_in_data,
               mem_address, mem_writedata, mem_read, mem_write
    );

    modport master (
        output save_req, restore_req, base_addr, rf_busywait, rf_out_data,
               mem_readdata, mem_busywait,
        input  busy, done, rf_read_mem, rf_write_mem, rf_in_data,
               mem_address, mem_writedata, mem_read, mem_write
    );
endinterface

// File: rtl/reg_context_dma.sv
// Context save/restore engine: moves the 32-word register file to or from
// data memory, one word per memory handshake beat.
module reg_context_dma (
    input  logic             clk_i,
    input  logic             rst_ni,
    reg_context_dma_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RF_SNAP = 3'd1;
    localparam logic [2:0] S_MEM_WR  = 3'd2;
    localparam logic [2:0] S_MEM_RD  = 3'd3;
    localparam logic [2:0] S_RF_LOAD = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [4:0]    index_q, index_d;
    logic [31:0]   base_q, base_d;
    logic [1023:0] buf_q, buf_d;
    logic          rf_seen_q, rf_seen_d;

    logic [31:0]   buf_word [32];
    logic          mem_req;
    logic          beat_done;
    logic          last_beat;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_word
            assign buf_word[gi] = buf_q[32*gi +: 32];
        end
    endgenerate

    assign mem_req   = (state_q == S_MEM_WR) || (state_q == S_MEM_RD);
    assign beat_done = mem_req && !bus.mem_busywait;
    assign last_beat = (index_q == 5'd31);

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        base_d    = base_q;
        buf_d     = buf_q;
        rf_seen_d = rf_seen_q;
        case (state_q)
            S_IDLE: begin
                index_d   = 5'd0;
                rf_seen_d = 1'b0;
                if (bus.save_req) begin
                    state_d = S_RF_SNAP;
                    base_d  = bus.base_addr & 32'hFFFF_FFFC;
                end else if (bus.restore_req) begin
                    state_d = S_MEM_RD;
                    base_d  = bus.base_addr & 32'hFFFF_FFFC;
                end
            end
            // Register-file transfers finish on the first idle edge after busy was seen.
            S_RF_SNAP: begin
                if (bus.rf_busywait) begin
                    rf_seen_d = 1'b1;
                end else if (rf_seen_q) begin
                    buf_d     = bus.rf_out_data;
                    rf_seen_d = 1'b0;
                    index_d   = 5'd0;
                    state_d   = S_MEM_WR;
                end
            end
            S_MEM_WR: begin
                if (beat_done) begin
                    if (last_beat) begin
                        state_d = S_FINISH;
                    end else begin
                        index_d = index_q + 5'd1;
                    end
                end
            end
            S_MEM_RD: begin
                if (beat_done) begin
                    // x0 is hardwired zero, so its saved image is never restored.
                    buf_d[{index_q, 5'd0} +: 32] = (index_q == 5'd0) ? 32'h0 : bus.mem_readdata;
                    if (last_beat) begin
                        state_d   = S_RF_LOAD;
                        rf_seen_d = 1'b0;
                    end else begin
                        index_d = index_q + 5'd1;
                    end
                end
            end
            S_RF_LOAD: begin
                if (bus.rf_busywait) begin
                    rf_seen_d = 1'b1;
                end else if (rf_seen_q) begin
                    rf_seen_d = 1'b0;
                    state_d   = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            index_q   <= 5'd0;
            base_q    <= 32'h0;
            buf_q     <= '0;
            rf_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            base_q    <= base_d;
            buf_q     <= buf_d;
            rf_seen_q <= rf_seen_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_FINISH);
    assign bus.rf_read_mem   = (state_q == S_RF_SNAP);
    assign bus.rf_write_mem  = (state_q == S_RF_LOAD);
    assign bus.mem_write     = (state_q == S_MEM_WR);
    assign bus.mem_read      = (state_q == S_MEM_RD);
    assign bus.mem_address   = mem_req ? (base_q + {25'd0, index_q, 2'b00}) : 32'h0;
    assign bus.mem_writedata = (state_q == S_MEM_WR) ? buf_word[index_q] : 32'h0;
    assign bus.rf_in_data    = buf_q;

endmodule
